// File: rtl/div_share_pkg.sv
// Shared constants and the in-flight tag record for the time-shared divider controller.
package div_share_pkg;

  localparam int N_REQ          = 4;
  localparam int DIVIDEND_WIDTH = 19;
  localparam int DIVISOR_WIDTH  = 11;
  localparam int DIV_LATENCY    = DIVIDEND_WIDTH + 1;
  localparam int IDX_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             zero;
  } tag_t;

endpackage

// File: rtl/div_share_ctrl_rr_arb.sv
// Round-robin arbiter: first requester after ptr (with wrap) wins, one-hot plus encoded index.
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  localparam int unsigned N = N_REQ;

  int unsigned k;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    k     = 0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!found && req[k[IDX_W-1:0]]) begin
        found                = 1'b1;
        gnt[k[IDX_W-1:0]]    = 1'b1;
        idx                  = k[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one fixed-latency pipelined divider among N_REQ requesters; tags ride a shift
// register aligned with the divider so each result is routed back to its requester.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int N_REQ          = div_share_pkg::N_REQ,
  parameter int DIVIDEND_WIDTH = div_share_pkg::DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = div_share_pkg::DIVISOR_WIDTH,
  parameter int DIV_LATENCY    = div_share_pkg::DIV_LATENCY
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  i_req,
  input  logic [N_REQ*DIVIDEND_WIDTH-1:0]   i_dividend,
  input  logic [N_REQ*DIVISOR_WIDTH-1:0]    i_divisor,
  output logic [N_REQ-1:0]                  o_ack,
  output logic                              o_div_en,
  output logic [DIVIDEND_WIDTH-1:0]         o_div_dividend,
  output logic [DIVISOR_WIDTH-1:0]          o_div_divisor,
  input  logic                              i_div_valid,
  input  logic [DIVIDEND_WIDTH-1:0]         i_div_quotient,
  input  logic [DIVISOR_WIDTH-1:0]          i_div_remainder,
  output logic [N_REQ-1:0]                  o_res_valid,
  output logic [DIVIDEND_WIDTH-1:0]         o_quotient,
  output logic [DIVISOR_WIDTH-1:0]          o_remainder,
  output logic                              o_div_zero,
  output logic                              o_idle,
  output logic                              o_err_align
);

  localparam int LAT_W = $clog2(DIV_LATENCY + 1);

  logic [N_REQ-1:0]            gnt;
  logic [IDX_W-1:0]            gnt_idx;
  logic [IDX_W-1:0]            ptr;
  logic [DIVIDEND_WIDTH-1:0]   sel_dividend;
  logic [DIVISOR_WIDTH-1:0]    sel_divisor;
  tag_t                        issue_tag;
  tag_t [DIV_LATENCY:1]        tags;
  tag_t                        last;
  logic [LAT_W-1:0]            mask_cnt;
  logic                        busy;

  rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (i_req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign o_ack        = gnt;
  assign o_div_en     = issue_tag.valid;
  assign sel_dividend = i_dividend[gnt_idx*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
  assign sel_divisor  = i_divisor[gnt_idx*DIVISOR_WIDTH +: DIVISOR_WIDTH];
  assign last         = tags[DIV_LATENCY];

  // Issue register: stage 0 of the tag pipeline, shares timing with o_div_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr            <= IDX_W'(N_REQ - 1);
      issue_tag      <= '0;
      o_div_dividend <= '0;
      o_div_divisor  <= '0;
    end else begin
      issue_tag <= '0;
      if (|gnt) begin
        ptr             <= gnt_idx;
        issue_tag.valid <= 1'b1;
        issue_tag.idx   <= gnt_idx;
        issue_tag.zero  <= (sel_divisor == '0);
        o_div_dividend  <= sel_dividend;
        o_div_divisor   <= sel_divisor;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags <= '0;
    end else begin
      tags <= {tags[DIV_LATENCY-1:1], issue_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_res_valid <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_div_zero  <= 1'b0;
    end else if (last.valid) begin
      o_res_valid <= N_REQ'(1) << last.idx;
      o_div_zero  <= last.zero;
      o_quotient  <= last.zero ? '1 : i_div_quotient;
      o_remainder <= last.zero ? '0 : i_div_remainder;
    end else begin
      o_res_valid <= '0;
    end
  end

  // The divider keeps draining pre-reset work, so alignment is not judged until it has flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_cnt    <= LAT_W'(DIV_LATENCY);
      o_err_align <= 1'b0;
    end else if (mask_cnt != '0) begin
      mask_cnt <= mask_cnt - LAT_W'(1);
    end else if (i_div_valid != last.valid) begin
      o_err_align <= 1'b1;
    end
  end

  always_comb begin
    busy = issue_tag.valid | (|o_res_valid);
    for (int unsigned s = 1; s <= DIV_LATENCY; s++) begin
      busy = busy | tags[s].valid;
    end
  end

  assign o_idle = !busy;

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Time-shares one fully pipelined, fixed-latency, non-stallable divider (one issue per clock) among N_REQ requesters in the video-processing path, e.g. per-channel normalisation and scaling.
- Round-robin arbitration; at most one division issued per cycle.
- Tracks each in-flight operation with a resettable tag pipeline aligned to the divider latency.
- Routes each quotient/remainder back to its originating requester with a one-hot valid.
- Sits between the requesters and the shared divider instance at the top level.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DIVIDEND_WIDTH, 19, dividend and quotient width.
- DIVISOR_WIDTH, 11, divisor and remainder width.
- DIV_LATENCY, DIVIDEND_WIDTH+1, divider cycles from a sampled enable to its valid output.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  N_REQ  per-requester request level; hold until acked
- i_dividend  in  N_REQ*DIVIDEND_WIDTH  packed dividends, requester k at slice k
- i_divisor  in  N_REQ*DIVISOR_WIDTH  packed divisors
- o_ack  out  N_REQ  one-hot grant, combinational; operands accepted at this edge
- o_div_en  out  1  divider enable, registered
- o_div_dividend  out  DIVIDEND_WIDTH  registered operand to divider
- o_div_divisor  out  DIVISOR_WIDTH  registered operand to divider
- i_div_valid  in  1  divider valid (checked only, never used for routing)
- i_div_quotient  in  DIVIDEND_WIDTH  divider quotient
- i_div_remainder  in  DIVISOR_WIDTH  divider remainder
- o_res_valid  out  N_REQ  one-hot result strobe, registered, single cycle
- o_quotient  out  DIVIDEND_WIDTH  result quotient
- o_remainder  out  DIVISOR_WIDTH  result remainder
- o_div_zero  out  1  result came from a zero divisor
- o_idle  out  1  no operation in flight
- o_err_align  out  1  sticky: i_div_valid disagreed with the internal valid pipeline

Behaviour:
- Reset: clears all registers. Outputs at reset: o_div_en=0, operands=0, o_res_valid=0, o_quotient=0, o_remainder=0, o_div_zero=0, o_idle=1, o_err_align=0, rr pointer=N_REQ-1.
- Arbitration:
  - o_ack = first set bit of i_req, searching from (ptr+1) mod N_REQ upward with wrap.
  - On a grant: pointer updates to the granted index; operands for that requester are registered onto o_div_* with o_div_en=1 the next cycle.
  - No request: o_div_en=0; operands hold their previous value.
  - No backpressure exists: a grant is possible every cycle, with at most one per cycle.
  - A requester deasserting i_req without an ack is legal; nothing is issued.
- Tag pipeline:
  - {valid, idx, zero} enters alongside o_div_en and shifts DIV_LATENCY stages.
  - Stage DIV_LATENCY is aligned with i_div_valid.
  - zero = (divisor == 0) at grant.
- Result stage (registered):
  - When the last tag is valid: o_res_valid[idx]=1; o_quotient/o_remainder take i_div_*; o_div_zero=zero.
  - When zero=1: quotient is forced to all ones and remainder to 0.
  - When the last tag is invalid: o_res_valid=0 and data holds.
- Latency: ack at edge t gives o_res_valid high in the cycle after edge t+DIV_LATENCY+1 (21 edges at defaults). Throughput is 1 result per cycle; results come back in issue order.
- o_idle = no valid bit in the issue register, tag stages or result register.
- o_err_align sets when i_div_valid != last tag valid. It clears only on reset.
- Reset mid-operation: all tags are cleared. Results the divider still emits for pre-reset issues are ignored; o_res_valid stays 0 until new issues complete. o_err_align is masked for DIV_LATENCY cycles after reset release, because the divider itself has no reset.
- Simultaneous requests: exactly one ack per cycle. Fairness: a continuously requesting requester is granted within N_REQ cycles.

Decomposition:
- Shared package div_share_pkg holds:
  - N_REQ, widths, DIV_LATENCY;
  - localparam IDX_W = clog2(N_REQ);
  - a tag struct {valid, idx[IDX_W], zero}.
- One sub-module: rr_arb (parameterised N_REQ). Inputs: request vector and pointer. Outputs: one-hot grant and encoded index.
- The tag shift register and result stage stay in the top.

Test Plan:
- Single op: i_req[2]=1, dividend=1000, divisor=7 → o_ack[2] at t; o_res_valid=4'b0100 at t+21 with quotient=142, remainder=6, o_div_zero=0.
- All four requesting continuously → acks 0,1,2,3,0,... one per cycle; results in the same order, back-to-back, each checked against a reference model.
- Divisor 0 from requester 1 (dividend=12345) → o_res_valid[1] with quotient=19'h7FFFF, remainder=0, o_div_zero=1.
- Reset pulsed 5 cycles after issuing 3 ops → no o_res_valid for those ops, o_idle=1 after release, o_err_align remains 0; new ops issued afterwards complete correctly.
- Requester 3 drops i_req before being granted while requester 0 also requests → no issue for requester 3, no spurious o_res_valid[3].
- Random 10k ops with random i_req patterns → every ack yields exactly one matching result after 21 edges; o_err_align never sets.
